// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl
//  Description : Bit-serial adder controller. Feeds one operand bit pair per
//                cycle to an external 1-bit full-adder slice, least significant
//                bit first, and assembles the registered WIDTH-bit result and
//                carry out.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy,
  output logic             done,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int                c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic               r_carry;
  logic [WIDTH-1:0]   r_acc;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_last;
  logic               w_load;

  // The final bit position closes the run; the counter never wraps into RUN.
  assign w_last = (r_cnt == c_LAST);

  // New operands are accepted from IDLE or from DONE (back-to-back); start is
  // ignored while a run is in progress so the latched operands stay stable.
  assign w_load = start && ((r_state == c_IDLE) || (r_state == c_DONE));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (start) w_state_nxt = c_RUN;
      c_RUN:   if (w_last) w_state_nxt = c_DONE;
      c_DONE:  w_state_nxt = start ? c_RUN : c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Outputs decoded from state only, so no input reaches an output combinationally
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    case (r_state)
      c_RUN: begin
        busy   = 1'b1;
        fa_a   = r_opa[r_cnt];
        fa_b   = r_opb[r_cnt];
        fa_cin = r_carry;
      end
      c_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, per-bit accumulation and result registration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
    end else if (w_load) begin
      r_opa   <= a;
      r_opb   <= b;
      r_carry <= c_in;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == c_RUN) begin
      r_acc[r_cnt] <= fa_sum;
      r_carry      <= fa_cout;
      if (w_last) begin
        // The top bit is still arriving from the slice, so merge it directly.
        sum   <= {fa_sum, r_acc[WIDTH-2:0]};
        c_out <= fa_cout;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Self-checking bench for serial_adder_ctrl with a gate-level
//                full-adder slice and an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;
  logic             done;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  wire              fa_sum;
  wire              fa_cout;

  wire w_x1;
  wire w_a1;
  wire w_a2;

  int n_vec = 0;
  int n_err = 0;

  // Result the DUT must keep presenting until the next completion
  logic [WIDTH-1:0] psum  = '0;
  logic             pcout = 1'b0;

  // Gate-level 1-bit full adder slice
  xor u_x1 (w_x1, fa_a, fa_b);
  xor u_x2 (fa_sum, w_x1, fa_cin);
  and u_a1 (w_a1, fa_a, fa_b);
  and u_a2 (w_a2, w_x1, fa_cin);
  or  u_o1 (fa_cout, w_a1, w_a2);

  serial_adder_ctrl #(.WIDTH(WIDTH)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .c_in    (c_in),
    .sum     (sum),
    .c_out   (c_out),
    .busy    (busy),
    .done    (done),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One complete addition, entered at a negedge while the DUT is in IDLE or
  // DONE. Returns at the negedge where done is visible when chain=1 (so the
  // next call starts back-to-back), otherwise after one idle cycle.
  // poke=1 re-asserts start (with other operands) so it is sampled at edge 3.
  task automatic op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                    input logic c, input bit chain, input bit poke);
    int          total;
    int          lo;
    int          mask;
    total = int'(x) + int'(y) + int'(c);
    start = 1'b1;
    a     = x;
    b     = y;
    c_in  = c;
    // Start is sampled at edge 0; the run occupies the WIDTH cycles after it.
    for (int k = 0; k < WIDTH; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        c_in  = 1'($urandom);
      end
      if (poke && k == 2) begin
        start = 1'b1;
        a     = 8'hF0;
        b     = 8'h0F;
      end
      if (poke && k == 3) start = 1'b0;
      mask = (1 << k) - 1;
      lo   = (int'(x) & mask) + (int'(y) & mask) + int'(c);
      check("run_busy",  32'(busy),   32'd1);
      check("run_done",  32'(done),   32'd0);
      check("run_sum",   32'(sum),    32'(psum));
      check("run_cout",  32'(c_out),  32'(pcout));
      check("run_fa_a",  32'(fa_a),   32'((int'(x) >> k) & 1));
      check("run_fa_b",  32'(fa_b),   32'((int'(y) >> k) & 1));
      check("run_fa_ci", 32'(fa_cin), 32'((lo >> k) & 1));
    end
    @(posedge clk);
    @(negedge clk);
    psum  = WIDTH'(total);
    pcout = 1'((total >> WIDTH) & 1);
    check("done_pulse", 32'(done),  32'd1);
    check("done_busy",  32'(busy),  32'd0);
    check("done_sum",   32'(sum),   32'(psum));
    check("done_cout",  32'(c_out), 32'(pcout));
    if (!chain) begin
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_sum",  32'(sum),  32'(psum));
      check("idle_cout", 32'(c_out), 32'(pcout));
      check("idle_fa",   32'({fa_a, fa_b, fa_cin}), 32'd0);
    end
  endtask

  initial begin
    bit ch;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sum",  32'(sum),   32'd0);
    check("rst_cout", 32'(c_out), 32'd0);
    check("rst_busy", 32'(busy),  32'd0);
    check("rst_done", 32'(done),  32'd0);
    check("rst_fa",   32'({fa_a, fa_b, fa_cin}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    check("dir_5a3c", 32'(sum), 32'h96);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Start re-asserted mid-run: no effect, and no second run afterwards
    op(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
    check("poke_sum", 32'(sum), 32'h33);
    repeat (3) begin
      @(negedge clk);
      check("poke_nobusy", 32'(busy), 32'd0);
      check("poke_nodone", 32'(done), 32'd0);
    end

    // Back-to-back: second start during the DONE cycle of the first
    op(8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
    op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges 4 and 5 of a run
    op(8'h77, 8'h22, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    a     = 8'hC3;
    b     = 8'h5A;
    c_in  = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy),  32'd0);
    check("arst_done", 32'(done),  32'd0);
    check("arst_sum",  32'(sum),   32'd0);
    check("arst_cout", 32'(c_out), 32'd0);
    #1 rst = 1'b0;
    psum  = '0;
    pcout = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("arst_nodone", 32'(done), 32'd0);
      check("arst_idle",   32'(busy), 32'd0);
      check("arst_sum0",   32'(sum),  32'd0);
    end

    // Randomised operations, randomly chained back-to-back
    for (int i = 0; i < 40; i++) begin
      ch = (i != 39) && ($urandom_range(0, 1) == 1);
      op(8'($urandom), 8'($urandom), 1'($urandom), ch, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
